// File: rtl/pc_sequencer_if.sv
// Datapath-facing bundle of the program counter sequencer.
// master = datapath/control side, slave = the sequencer itself.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             branch;
  logic             alu_zero;
  logic [WIDTH-1:0] branch_offset;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             halt;
  logic             resume;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] branch_target;
  logic             redirect;
  logic             flush;
  logic             fetch_valid;

  modport master (
    output stall, branch, alu_zero, branch_offset, jump, jump_target, halt, resume,
    input  pc_out, pc_seq, branch_target, redirect, flush, fetch_valid
  );

  modport slave (
    input  stall, branch, alu_zero, branch_offset, jump, jump_target, halt, resume,
    output pc_out, pc_seq, branch_target, redirect, flush, fetch_valid
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: reset vector, stall hold, jump, conditional branch,
// post-redirect flush window and a halt/resume state machine.
module pc_sequencer #(
  parameter int unsigned      WIDTH           = 32,
  parameter logic [WIDTH-1:0] INC             = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_VECTOR    = '0,
  parameter bit               BRANCH_BASE_SEQ = 1'b1,
  parameter int unsigned      FLUSH_CYCLES    = 2
) (
  input logic            clock,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

  state_e           state;
  logic [3:0]       flush_cnt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] branch_target;
  logic             redirect;
  logic             flush;
  logic             fetch_valid;
  logic             taken;
  logic             redirect_req;

  // Combinational next-address candidates; all arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    pc_seq        = pc + INC;
    branch_target = (BRANCH_BASE_SEQ ? pc_seq : pc) + bus.branch_offset;
    taken         = bus.branch & bus.alu_zero;
    redirect_req  = bus.jump | taken;
  end

  // Sequencer state, PC and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= StRun;
      pc          <= RESET_VECTOR;
      flush_cnt   <= '0;
      redirect    <= 1'b0;
      flush       <= 1'b0;
      fetch_valid <= 1'b1;
    end else begin
      unique case (state)
        StRun, StFlush: begin
          if (bus.halt) begin
            state       <= StHalt;
            flush_cnt   <= '0;
            redirect    <= 1'b0;
            flush       <= 1'b0;
            fetch_valid <= 1'b0;
          end else if (redirect_req) begin
            // A resolved redirect wins over a stall and restarts the flush window.
            pc        <= bus.jump ? bus.jump_target : branch_target;
            state     <= StFlush;
            flush_cnt <= FLUSH_LOAD;
            redirect  <= 1'b1;
            flush     <= 1'b1;
          end else begin
            redirect <= 1'b0;
            if (!bus.stall) begin
              pc <= pc_seq;
              // The flush window only counts cycles in which the pipe advanced.
              if (state == StFlush) begin
                flush_cnt <= flush_cnt - 4'd1;
                if (flush_cnt <= 4'd1) begin
                  state <= StRun;
                  flush <= 1'b0;
                end
              end
            end
          end
        end
        StHalt: begin
          redirect <= 1'b0;
          flush    <= 1'b0;
          if (bus.resume && !bus.halt) begin
            state       <= StRun;
            fetch_valid <= 1'b1;
          end
        end
        default: begin
          state     <= StRun;
          flush_cnt <= '0;
          flush     <= 1'b0;
        end
      endcase
    end
  end

  // Drive the bundle.
  always_comb begin
    bus.pc_out        = pc;
    bus.pc_seq        = pc_seq;
    bus.branch_target = branch_target;
    bus.redirect      = redirect;
    bus.flush         = flush;
    bus.fetch_valid   = fetch_valid;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three differently configured instances share one stimulus
// stream; directed scenarios check hand-derived values, a random run checks a model.
module tb_pc_sequencer;

  // Instance configs: 0 = 32b/INC4/RV 0x100/seq base/flush 2,
  // 1 = 8b/INC1/RV 0/pc base/flush 3, 2 = 16b/INC1/RV 0/seq base/flush 2.
  localparam logic [31:0] MASK  [3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_FFFF};
  localparam logic [31:0] CINC  [3] = '{32'd4, 32'd1, 32'd1};
  localparam logic [31:0] CRV   [3] = '{32'h100, 32'h0, 32'h0};
  localparam bit          CBASE [3] = '{1'b1, 1'b0, 1'b1};
  localparam int          CFL   [3] = '{2, 3, 2};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall, branch, alu_zero, jump, halt, resume;
  logic [31:0] offset, jtarget;

  int checks   = 0;
  int failures = 0;

  pc_sequencer_if #(.WIDTH(32)) ifa ();
  pc_sequencer_if #(.WIDTH(8))  ifb ();
  pc_sequencer_if #(.WIDTH(16)) ifc ();

  assign ifa.stall = stall;  assign ifb.stall = stall;  assign ifc.stall = stall;
  assign ifa.branch = branch;  assign ifb.branch = branch;  assign ifc.branch = branch;
  assign ifa.alu_zero = alu_zero;  assign ifb.alu_zero = alu_zero;
  assign ifc.alu_zero = alu_zero;
  assign ifa.branch_offset = offset;
  assign ifb.branch_offset = offset[7:0];
  assign ifc.branch_offset = offset[15:0];
  assign ifa.jump = jump;  assign ifb.jump = jump;  assign ifc.jump = jump;
  assign ifa.jump_target = jtarget;
  assign ifb.jump_target = jtarget[7:0];
  assign ifc.jump_target = jtarget[15:0];
  assign ifa.halt = halt;  assign ifb.halt = halt;  assign ifc.halt = halt;
  assign ifa.resume = resume;  assign ifb.resume = resume;  assign ifc.resume = resume;

  pc_sequencer #(.WIDTH(32), .INC(32'd4), .RESET_VECTOR(32'h100), .BRANCH_BASE_SEQ(1'b1),
                 .FLUSH_CYCLES(2)) dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
  pc_sequencer #(.WIDTH(8), .INC(8'd1), .RESET_VECTOR(8'h0), .BRANCH_BASE_SEQ(1'b0),
                 .FLUSH_CYCLES(3)) dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));
  pc_sequencer #(.WIDTH(16), .INC(16'd1), .RESET_VECTOR(16'h0), .BRANCH_BASE_SEQ(1'b1),
                 .FLUSH_CYCLES(2)) dut_c (.clock(clock), .reset(reset), .bus(ifc.slave));

  always #5 clock = ~clock;

  // Observed outputs, zero-extended to 32 bits and indexed by instance.
  logic [31:0] d_pc [3];
  logic [31:0] d_seq [3];
  logic [31:0] d_bt [3];
  logic        d_red [3];
  logic        d_fl [3];
  logic        d_fv [3];

  always_comb begin
    d_pc[0] = ifa.pc_out;  d_pc[1] = 32'(ifb.pc_out);  d_pc[2] = 32'(ifc.pc_out);
    d_seq[0] = ifa.pc_seq;  d_seq[1] = 32'(ifb.pc_seq);  d_seq[2] = 32'(ifc.pc_seq);
    d_bt[0] = ifa.branch_target;  d_bt[1] = 32'(ifb.branch_target);
    d_bt[2] = 32'(ifc.branch_target);
    d_red[0] = ifa.redirect;  d_red[1] = ifb.redirect;  d_red[2] = ifc.redirect;
    d_fl[0] = ifa.flush;  d_fl[1] = ifb.flush;  d_fl[2] = ifc.flush;
    d_fv[0] = ifa.fetch_valid;  d_fv[1] = ifb.fetch_valid;  d_fv[2] = ifc.fetch_valid;
  end

  // Reference model: PC, halted flag, remaining flush cycles, last-edge-redirected flag.
  logic [31:0] m_pc [3];
  bit          m_halted [3];
  int          m_left [3];
  bit          m_red [3];

  task automatic model_step(input int k);
    logic [31:0] seq;
    logic [31:0] bt;
    seq = (m_pc[k] + CINC[k]) & MASK[k];
    bt  = ((CBASE[k] ? seq : m_pc[k]) + offset) & MASK[k];
    if (reset) begin
      m_pc[k] = CRV[k];  m_halted[k] = 1'b0;  m_left[k] = 0;  m_red[k] = 1'b0;
    end else if (m_halted[k]) begin
      m_red[k] = 1'b0;
      if (resume && !halt) m_halted[k] = 1'b0;
    end else if (halt) begin
      m_halted[k] = 1'b1;  m_left[k] = 0;  m_red[k] = 1'b0;
    end else if (jump || (branch && alu_zero)) begin
      m_pc[k] = (jump ? jtarget : bt) & MASK[k];
      m_red[k] = 1'b1;
      m_left[k] = CFL[k];
    end else begin
      m_red[k] = 1'b0;
      if (!stall) begin
        m_pc[k] = seq;
        if (m_left[k] > 0) m_left[k]--;
      end
    end
  endtask

  task automatic idle();
    stall = 0;  branch = 0;  alu_zero = 0;  jump = 0;  halt = 0;  resume = 0;
    offset = '0;  jtarget = '0;
  endtask

  // One clock edge; the model advances on the same edge, outputs settle by #1.
  task automatic cycle();
    @(posedge clock);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    cycle();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_pc[k] !== CRV[k]) begin
        failures++;  $display("FAIL reset_pc dut%0d: got %0h expected %0h", k, d_pc[k], CRV[k]);
      end
      checks++;
      if ({d_fv[k], d_fl[k], d_red[k]} !== 3'b100) begin
        failures++;
        $display("FAIL reset_flags dut%0d: got fv/fl/red %b%b%b expected 100",
                 k, d_fv[k], d_fl[k], d_red[k]);
      end
    end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h100, 32'h104, 32'h108, 32'h10C};
    idle();
    reset = 1;
    cycle();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle();
      checks++;
      if (d_pc[0] !== exp_pc[i] || d_fv[0] !== 1'b1 || d_fl[0] !== 1'b0) begin
        failures++;
        $display("FAIL free_run step %0d: got pc %0h fv %b fl %b expected pc %0h fv 1 fl 0",
                 i, d_pc[0], d_fv[0], d_fl[0], exp_pc[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc [3];
    logic        exp_fl [3];
    exp_pc = '{32'h3, 32'h4, 32'h5};
    exp_fl = '{1'b1, 1'b1, 1'b0};
    idle();  jump = 1;  jtarget = 32'h3;
    cycle();
    idle();
    cycle();
    cycle();
    checks++;
    if (d_pc[2] !== 32'h5 || d_fl[2] !== 1'b0) begin
      failures++;
      $display("FAIL branch_setup: got pc %0h fl %b expected pc 5 fl 0", d_pc[2], d_fl[2]);
    end
    branch = 1;  alu_zero = 1;  offset = 32'hFFFF_FFFD;
    for (int i = 0; i < 3; i++) begin
      cycle();
      idle();
      checks++;
      if (d_pc[2] !== exp_pc[i] || d_fl[2] !== exp_fl[i] || d_red[2] !== (i == 0)) begin
        failures++;
        $display("FAIL branch_taken step %0d: got pc %0h fl %b red %b expected pc %0h fl %b",
                 i, d_pc[2], d_fl[2], d_red[2], exp_pc[i], exp_fl[i]);
      end
    end
    branch = 1;  alu_zero = 0;  offset = 32'hFFFF_FFFD;
    cycle();
    idle();
    checks++;
    if (d_pc[2] !== 32'h6 || d_fl[2] !== 1'b0 || d_red[2] !== 1'b0) begin
      failures++;
      $display("FAIL branch_not_taken: got pc %0h fl %b red %b expected pc 6 fl 0 red 0",
               d_pc[2], d_fl[2], d_red[2]);
    end
  endtask

  task automatic test_stall_jump();
    idle();  jump = 1;  jtarget = 32'h8;
    cycle();
    idle();
    cycle();
    cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (d_pc[2] !== 32'hA) begin
        failures++;  $display("FAIL stall_hold %0d: got pc %0h expected a", i, d_pc[2]);
      end
    end
    jump = 1;  jtarget = 32'h40;
    cycle();
    idle();
    checks++;
    if (d_pc[2] !== 32'h40 || d_red[2] !== 1'b1 || d_fl[2] !== 1'b1) begin
      failures++;
      $display("FAIL stall_jump: got pc %0h red %b fl %b expected pc 40 red 1 fl 1",
               d_pc[2], d_red[2], d_fl[2]);
    end
  endtask

  task automatic test_flush_reload();
    logic exp_a [3];
    logic exp_b [5];
    exp_a = '{1'b1, 1'b1, 1'b0};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    idle();  jump = 1;  jtarget = 32'h20;
    cycle();
    idle();
    cycle();
    branch = 1;  alu_zero = 1;  offset = 32'h4;
    cycle();
    idle();
    checks++;
    if (d_pc[1] !== 32'h25 || d_red[1] !== 1'b1 || d_fl[1] !== 1'b1) begin
      failures++;
      $display("FAIL reload_branch: got pc %0h red %b fl %b expected pc 25 red 1 fl 1",
               d_pc[1], d_red[1], d_fl[1]);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (d_fl[1] !== exp_a[i]) begin
        failures++;  $display("FAIL reload_flush %0d: got %b expected %b", i, d_fl[1], exp_a[i]);
      end
    end
    jump = 1;  jtarget = 32'h30;
    cycle();
    idle();
    for (int i = 0; i < 5; i++) begin
      stall = (i < 2);
      cycle();
      checks++;
      if (d_fl[1] !== exp_b[i]) begin
        failures++;  $display("FAIL stall_flush %0d: got %b expected %b", i, d_fl[1], exp_b[i]);
      end
    end
    idle();
  endtask

  task automatic test_halt();
    idle();  jump = 1;  jtarget = 32'h7;
    cycle();
    idle();  halt = 1;
    cycle();
    checks++;
    if (d_pc[2] !== 32'h7 || {d_fv[2], d_fl[2], d_red[2]} !== 3'b000) begin
      failures++;
      $display("FAIL halt_enter: got pc %0h fv/fl/red %b%b%b expected pc 7 000",
               d_pc[2], d_fv[2], d_fl[2], d_red[2]);
    end
    idle();  jump = 1;  jtarget = 32'h55;  stall = 1;  branch = 1;  alu_zero = 1;
    cycle();
    checks++;
    if (d_pc[2] !== 32'h7 || {d_fv[2], d_fl[2], d_red[2]} !== 3'b000) begin
      failures++;
      $display("FAIL halt_ignore: got pc %0h fv/fl/red %b%b%b expected pc 7 000",
               d_pc[2], d_fv[2], d_fl[2], d_red[2]);
    end
    idle();  halt = 1;  resume = 1;
    cycle();
    checks++;
    if (d_fv[2] !== 1'b0) begin
      failures++;  $display("FAIL halt_and_resume: got fv %b expected 0", d_fv[2]);
    end
    idle();  resume = 1;
    cycle();
    idle();
    checks++;
    if (d_pc[2] !== 32'h7 || d_fv[2] !== 1'b1) begin
      failures++;
      $display("FAIL resume: got pc %0h fv %b expected pc 7 fv 1", d_pc[2], d_fv[2]);
    end
    cycle();
    checks++;
    if (d_pc[2] !== 32'h8) begin
      failures++;  $display("FAIL resume_advance: got pc %0h expected 8", d_pc[2]);
    end
  endtask

  task automatic test_wrap();
    idle();  jump = 1;  jtarget = 32'hFFFF_FFFF;
    cycle();
    idle();
    checks++;
    if (d_seq[1] !== 32'h0 || d_seq[2] !== 32'h0 || d_seq[0] !== 32'h3) begin
      failures++;
      $display("FAIL wrap_seq: got %0h/%0h/%0h expected 3/0/0", d_seq[0], d_seq[1], d_seq[2]);
    end
    cycle();
    checks++;
    if (d_pc[1] !== 32'h0 || d_pc[2] !== 32'h0 || d_pc[0] !== 32'h3) begin
      failures++;
      $display("FAIL wrap_pc: got %0h/%0h/%0h expected 3/0/0", d_pc[0], d_pc[1], d_pc[2]);
    end
  endtask

  task automatic test_reset_override();
    idle();  jump = 1;  jtarget = 32'h44;
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_pc[k] !== CRV[k] || {d_fv[k], d_fl[k], d_red[k]} !== 3'b100) begin
        failures++;
        $display("FAIL reset_in_flush dut%0d: got pc %0h fv/fl/red %b%b%b expected pc %0h 100",
                 k, d_pc[k], d_fv[k], d_fl[k], d_red[k], CRV[k]);
      end
    end
    idle();  halt = 1;
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    idle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_pc[k] !== CRV[k] || {d_fv[k], d_fl[k]} !== 2'b10) begin
        failures++;
        $display("FAIL reset_in_halt dut%0d: got pc %0h fv/fl %b%b expected pc %0h 10",
                 k, d_pc[k], d_fv[k], d_fl[k], CRV[k]);
      end
    end
    cycle();
    checks++;
    if (d_pc[0] !== 32'h104) begin
      failures++;  $display("FAIL reset_then_run: got pc %0h expected 104", d_pc[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_seq;
    logic [31:0] e_bt;
    idle();
    reset = 1;
    cycle();
    reset = 0;
    for (int n = 0; n < 1500; n++) begin
      reset    = ($urandom_range(0, 63) == 0);
      halt     = ($urandom_range(0, 15) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      jump     = ($urandom_range(0, 7) == 0);
      branch   = ($urandom_range(0, 3) == 0);
      alu_zero = ($urandom_range(0, 1) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      offset   = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 63)) - 32'd32;
      jtarget  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 8))
                                             : $urandom();
      #1;
      for (int k = 0; k < 3; k++) begin
        e_seq = (m_pc[k] + CINC[k]) & MASK[k];
        e_bt  = ((CBASE[k] ? e_seq : m_pc[k]) + offset) & MASK[k];
        checks++;
        if (d_seq[k] !== e_seq || d_bt[k] !== e_bt) begin
          failures++;
          $display("FAIL rand_comb dut%0d n%0d: got seq %0h bt %0h expected seq %0h bt %0h",
                   k, n, d_seq[k], d_bt[k], e_seq, e_bt);
        end
      end
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_pc[k] !== m_pc[k]) begin
          failures++;
          $display("FAIL rand_pc dut%0d n%0d: got %0h expected %0h", k, n, d_pc[k], m_pc[k]);
        end
        checks++;
        if (d_red[k] !== m_red[k] || d_fl[k] !== (m_left[k] > 0) || d_fv[k] !== !m_halted[k])
        begin
          failures++;
          $display("FAIL rand_flags dut%0d n%0d: got red/fl/fv %b%b%b expected %b%b%b",
                   k, n, d_red[k], d_fl[k], d_fv[k], m_red[k], (m_left[k] > 0), !m_halted[k]);
        end
      end
    end
    idle();
    reset = 0;
  endtask

  initial begin
    idle();
    test_reset();
    test_free_run();
    test_branch();
    test_stall_jump();
    test_flush_reload();
    test_halt();
    test_wrap();
    test_reset_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time bound so a stuck run still ends with a report.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program counter for the single-cycle/pipelined datapath; next generation of the existing PC block.
- Adds synchronous reset to a vector, a stall hold, absolute jump, conditional branch with selectable base, a flush window after redirects, and a halt/resume state machine.
- Drives instruction-memory address and branch-target/sequential-PC values to the datapath.

Parameters:
- WIDTH, 32, PC and offset width in bits.
- INC, 1, sequential increment; 1 = word-addressed memory, 4 = byte-addressed.
- RESET_VECTOR, 0, PC value loaded on reset.
- BRANCH_BASE_SEQ, 1, 1 = branch target = (PC+INC)+offset; 0 = PC+offset.
- FLUSH_CYCLES, 2, cycles flush is held after a taken redirect; range 1..15.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; no sequential advance.
- branch  in  1  current instruction is a conditional branch.
- alu_zero  in  1  branch condition from ALU.
- branch_offset  in  WIDTH  sign-extended branch offset.
- jump  in  1  unconditional absolute jump.
- jump_target  in  WIDTH  absolute jump address.
- halt  in  1  request halt.
- resume  in  1  leave halt.
- pc_out  out  WIDTH  current PC (registered).
- pc_seq  out  WIDTH  pc_out+INC (combinational).
- branch_target  out  WIDTH  computed branch target (combinational).
- redirect  out  1  registered one-cycle pulse: previous edge loaded a jump/branch target.
- flush  out  1  registered; kill younger pipeline stages.
- fetch_valid  out  1  registered; pc_out is a valid fetch address.

Behaviour:
- Reset (sampled at rising edge): pc_out=RESET_VECTOR, redirect=0, flush=0, fetch_valid=1, flush counter=0, state=RUN. Reset overrides every other input, including mid-flush and in HALT.
- Arithmetic modulo 2^WIDTH; pc_seq and branch_target wrap silently (pc_out=2^WIDTH-1, INC=1 -> pc_seq=0).
- branch_target = BRANCH_BASE_SEQ ? pc_seq+branch_offset : pc_out+branch_offset.
- taken = branch & alu_zero.
- States: RUN, FLUSH, HALT.
- Next-PC priority in RUN/FLUSH, highest first: halt, jump, taken, stall, sequential.
  - halt: PC unchanged, go HALT, fetch_valid=0 next cycle.
  - jump: pc_out<=jump_target.
  - taken: pc_out<=branch_target.
  - stall: pc_out unchanged.
  - otherwise: pc_out<=pc_seq.
  - jump/taken override stall (redirect resolved in the stalling stage wins).
- Redirect (jump or taken, without halt):
  - redirect=1 for exactly the next cycle.
  - flush=1 and counter loaded with FLUSH_CYCLES; go FLUSH.
- FLUSH:
  - flush stays 1 while counter>0.
  - Counter decrements only on non-stalled cycles; return to RUN when the counter reaches 0 (flush=0 that cycle).
  - A new redirect in FLUSH reloads the counter to FLUSH_CYCLES.
- HALT:
  - pc_out frozen; fetch_valid=0; flush=0; redirect=0; branch/jump/stall ignored.
  - resume=1 -> RUN next edge, fetch_valid=1, PC unchanged (resumes at the halted address).
  - halt and resume both high in HALT: stay HALT.
- Latency: all PC updates take effect one clock after the inputs are sampled. Combinational outputs reflect the current pc_out and inputs.

Test Plan:
- Reset then 4 free-running cycles, RESET_VECTOR=0x100, INC=4 -> pc_out 0x100, 0x104, 0x108, 0x10C; fetch_valid=1, flush=0.
- At pc_out=5 (INC=1, BRANCH_BASE_SEQ=1), branch=1, alu_zero=1, offset=-3 -> next pc_out=3; redirect pulses 1 cycle; flush=1 for 2 cycles, then 0. Same with alu_zero=0 -> pc_out=6, no flush.
- stall=1 for 3 cycles at pc_out=10 -> pc_out stays 10. jump=1, target=0x40 while stalled -> pc_out=0x40, redirect=1.
- Redirect during flush with FLUSH_CYCLES=3: second branch on the 2nd flush cycle -> flush held 3 further unstalled cycles. Stall inserted during flush -> flush extended by the number of stall cycles.
- halt at pc_out=7 -> pc_out frozen at 7, fetch_valid=0, jump ignored. resume -> fetch_valid=1, pc_out 7 then 8.
- Wrap, WIDTH=8, INC=1, pc_out=0xFF -> next 0x00. reset asserted mid-FLUSH and in HALT -> pc_out=RESET_VECTOR, flush=0, fetch_valid=1 next cycle.
